// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline IF/MEM and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;
    logic            if_stall;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_valid;
    logic            d_stall;

    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_be;
    logic [DW-1:0]   m_rdata;
    logic            m_ready;
    logic            bus_err;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               m_req, m_we, m_addr, m_wdata, m_be, bus_err
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               m_req, m_we, m_addr, m_wdata, m_be, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one single-ported memory; MEM_ARB_TIMEOUT_EN adds busy abort
// MEM stage has priority; a streak limiter hands the port to IF after IF_STARVE_MAX back-to-back D grants.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int IF_STARVE_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(IF_STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;

    state_e          state_q, state_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [BW-1:0]   m_be_q, m_be_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            d_valid_q, d_valid_d;
    logic            drop_q, drop_d;
    logic [SW-1:0]   streak_q, streak_d;

    logic if_elig, d_elig, gap, grant_if, grant_d, done, abort, finish;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          bus_err_q, bus_err_d;
    assign abort = (state_q != IDLE) && !bus.m_ready && (busy_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err = bus_err_q;
`else
    assign abort = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    // A completion pulse cycle is the mandatory idle gap between transactions,
    // which is what lets a continuously requesting MEM stage build up a streak.
    assign if_elig  = bus.if_req && !if_valid_q && !bus.if_flush;
    assign d_elig   = bus.d_req && !d_valid_q;
    assign gap      = if_valid_q || d_valid_q;
    assign grant_if = (state_q == IDLE) && !gap && if_elig &&
                      (!d_elig || streak_q == SW'(IF_STARVE_MAX));
    assign grant_d  = (state_q == IDLE) && !gap && d_elig && !grant_if;
    assign done     = (state_q != IDLE) && bus.m_ready;
    assign finish   = done || abort;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            rdata_q    <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            drop_q     <= 1'b0;
            streak_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt_q <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            rdata_q    <= rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            drop_q     <= drop_d;
            streak_q   <= streak_d;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt_q <= busy_cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if)     state_d = IF_BUSY;
                else if (grant_d) state_d = D_BUSY;
            end
            IF_BUSY, D_BUSY: begin
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        rdata_d    = rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        drop_d     = drop_q;
        streak_d   = streak_q;

        if (grant_if) begin
            m_req_d  = 1'b1;
            m_we_d   = 1'b0;
            m_addr_d = bus.if_addr;
            m_be_d   = '0;
            streak_d = '0;
        end else if (grant_d) begin
            m_req_d   = 1'b1;
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_be_d    = bus.d_be;
            if (!bus.if_req)                        streak_d = '0;
            else if (streak_q != SW'(IF_STARVE_MAX)) streak_d = streak_q + SW'(1);
        end

        if (state_q == IF_BUSY && bus.if_flush) drop_d = 1'b1;

        // A flushed fetch still runs to completion at the memory; only its pulse is dropped.
        if (finish) begin
            m_req_d    = 1'b0;
            rdata_d    = done ? bus.m_rdata : DW'(32'hDEAD_BEEF);
            if_valid_d = (state_q == IF_BUSY) && !drop_q && !bus.if_flush;
            d_valid_d  = (state_q == D_BUSY);
            drop_d     = 1'b0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_comb begin
        busy_cnt_d = (state_q == IDLE) ? '0 : busy_cnt_q + CW'(1);
        bus_err_d  = bus_err_q | abort;
    end
`endif

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_be     = m_be_q;
    assign bus.if_rdata = rdata_q;
    assign bus.d_rdata  = rdata_q;
    assign bus.if_valid = if_valid_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.if_stall = bus.if_req && !if_valid_q;
    assign bus.d_stall  = bus.d_req && !d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .IF_STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [32:0] exp_if[$];
    logic [32:0] exp_d[$];
    logic [31:0] grant_log[$];

    int   lat         = 0;
    bit   mem_en      = 1'b1;
    logic resp_ready  = 1'b0;
    logic extra_ready = 1'b0;

    assign bus.m_ready = resp_ready | extra_ready;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers lat cycles after m_req rises, checks command stability.
    initial begin : responder
        int          lat_cnt;
        logic        prev_req;
        logic [68:0] cmd;
        lat_cnt = 0;
        prev_req = 1'b0;
        cmd = '0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.m_req === 1'b1 && prev_req !== 1'b1) begin
                grant_log.push_back(bus.m_addr);
                cmd = {bus.m_we, bus.m_be, bus.m_wdata, bus.m_addr};
            end else if (bus.m_req === 1'b1) begin
                check("m_cmd_stable", {bus.m_we, bus.m_be, bus.m_wdata, bus.m_addr}, cmd);
            end
            prev_req = bus.m_req;
            if (bus.m_req === 1'b1 && mem_en && !resp_ready) begin
                if (lat_cnt == lat) begin
                    resp_ready = 1'b1;
                    bus.m_rdata = mem_data(bus.m_addr);
                end else begin
                    lat_cnt++;
                end
            end else begin
                resp_ready = 1'b0;
                lat_cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rstn && bus.if_valid === 1'b1) begin
                check("if_stall_on_valid", bus.if_stall, 0);
                if (exp_if.size() == 0) check("if_valid_unexpected", 1, 0);
                else begin
                    e = exp_if.pop_front();
                    check("if_rdata", bus.if_rdata, e[31:0]);
                end
            end
            if (rstn && bus.d_valid === 1'b1) begin
                check("d_stall_on_valid", bus.d_stall, 0);
                if (exp_d.size() == 0) check("d_valid_unexpected", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    if (!e[32]) check("d_rdata", bus.d_rdata, e[31:0]);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output int lat_c);
        int c0;
        bit got;
        @(posedge clk); #1;
        exp_if.push_back({1'b0, mem_data(a)});
        bus.if_req = 1'b1;
        bus.if_addr = a;
        c0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (bus.if_valid === 1'b1);
        end
        if (!got) check("if_wait_timeout", 0, 1);
        lat_c = cyc - c0;
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic dmem(input int n, input logic [31:0] base, input bit we,
                        input logic [3:0] be, input logic [31:0] wd);
        bit got;
        @(posedge clk); #1;
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_be = be;
        bus.d_wdata = wd;
        for (int k = 0; k < n; k++) begin
            bus.d_addr = base + 32'(4 * k);
            exp_d.push_back({we, mem_data(bus.d_addr)});
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = (bus.d_valid === 1'b1);
            end
            if (!got) check("d_wait_timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
    endtask

    task automatic wait_mreq();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (bus.m_req === 1'b1);
        end
        if (!got) check("m_req_wait_timeout", 0, 1);
    endtask

    initial begin : main
        int l;
        logic [31:0] order[6];
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_d_valid", bus.d_valid, 0);
        check("rst_rdata", bus.if_rdata, 0);
        check("rst_bus_err", bus.bus_err, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Fetch only, memory answers 2 cycles after m_req
        lat = 2;
        fetch(32'h100, l);
        check("if_latency", l, 4);

        // Simultaneous load and fetch: MEM first
        lat = 0;
        grant_log.delete();
        fork
            dmem(1, 32'h2000, 1'b0, 4'h0, 32'h0);
            fetch(32'h104, l);
        join
        check("prio_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("prio_first_d", grant_log[0], 32'h2000);
            check("prio_then_if", grant_log[1], 32'h104);
        end

        // Back-to-back loads with a pending fetch: 4 D grants, then IF
        lat = 1;
        grant_log.delete();
        order = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h400, 32'h3010};
        fork
            dmem(5, 32'h3000, 1'b0, 4'h0, 32'h0);
            fetch(32'h400, l);
        join
        check("starve_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check($sformatf("starve_order_%0d", i), grant_log[i], order[i]);

        // Flush during IF_BUSY: old fetch dropped, redirect fetch served
        lat = 3;
        grant_log.delete();
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h180;
        wait_mreq();
        @(posedge clk); #1;
        bus.if_flush = 1'b1;
        @(negedge clk);
        check("if_stall_busy", bus.if_stall, 1);
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        bus.if_addr = 32'h200;
        exp_if.push_back({1'b0, mem_data(32'h200)});
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = (bus.if_valid === 1'b1);
            end
            if (!got) check("flush_wait_timeout", 0, 1);
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        check("flush_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("flush_new_target", grant_log[1], 32'h200);

        // Store with partial byte enables
        lat = 2;
        fork
            dmem(1, 32'h2400, 1'b1, 4'b0011, 32'hAABB_CCDD);
            begin
                wait_mreq();
                check("st_m_we", bus.m_we, 1);
                check("st_m_be", bus.m_be, 4'b0011);
                check("st_m_wdata", bus.m_wdata, 32'hAABB_CCDD);
                check("st_m_addr", bus.m_addr, 32'h2400);
            end
        join

        // Reset mid-transaction, then a stray m_ready while idle
        lat = 6;
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h500;
        wait_mreq();
        @(posedge clk); #1;
        rstn = 1'b0;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_m_req", bus.m_req, 0);
        @(posedge clk); #1;
        extra_ready = 1'b1;
        @(posedge clk); #1;
        extra_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_ready_m_req", bus.m_req, 0);
        check("idle_ready_rdata", bus.if_rdata, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort after 8 busy cycles
        mem_en = 1'b0;
        begin
            int c0;
            bit got;
            @(posedge clk); #1;
            bus.d_req = 1'b1;
            bus.d_we = 1'b0;
            bus.d_addr = 32'h2800;
            exp_d.push_back({1'b0, 32'hDEAD_BEEF});
            c0 = cyc;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = (bus.d_valid === 1'b1);
            end
            if (!got) check("to_wait_timeout", 0, 1);
            check("to_latency", cyc - c0, 9);
            @(posedge clk); #1;
            bus.d_req = 1'b0;
        end
        mem_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("to_bus_err_sticky", bus.bus_err, 1);
        check("to_m_req_low", bus.m_req, 0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("to_bus_err_reset", bus.bus_err, 0);
`else
        check("bus_err_tied", bus.bus_err, 0);
`endif

        repeat (4) @(posedge clk);
        check("if_queue_drained", exp_if.size(), 0);
        check("d_queue_drained", exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
